// File: rtl/spi_mem_ctrl.sv
// Bus-to-SPI memory bridge: turns byte/half/word bus requests into SPI master
// transactions and keeps a sequential instruction-fetch session open between fetches.
module spi_mem_ctrl #(
  parameter logic [7:0] CMD_READ     = 8'h03,
  parameter logic [7:0] CMD_WRITE    = 8'h02,
  parameter logic [7:0] SESS_TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        rst_n,
  // A request transfers on any rising edge where req_valid && req_ready; the
  // fields are captured then, and req_valid may drop afterwards without effect.
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_instr,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [23:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        m_start,
  output logic        m_stop,
  output logic        m_cont_read,
  output logic        m_write_enable,
  output logic        m_is_instr,
  output logic [31:0] m_cmd_addr,
  output logic [5:0]  m_data_len,
  output logic [31:0] m_data_in,
  input  logic [31:0] m_data_out,
  input  logic        m_done,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {IDLE, STOP, START, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic        sess_open_q, sess_open_d;
  logic [23:0] sess_next_q, sess_next_d;
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;
  logic        stop_only_q, stop_only_d;
  logic        cont_q, cont_d;
  logic        we_q, we_d;
  logic        instr_q, instr_d;
  logic [31:0] cmd_addr_q, cmd_addr_d;
  logic [5:0]  data_len_q, data_len_d;
  logic [31:0] data_in_q, data_in_d;
  logic [31:0] rdata_q, rdata_d;

  logic        timeout_fire;
  logic        accept;
  logic        is_write;
  logic [5:0]  req_len;
  logic [31:0] wr_fmt;
  logic [31:0] rd_fmt;

  // Request-side formatting: SPI shifts MSB first, the bus is little-endian.
  always_comb begin
    is_write = req_we && !req_is_instr;
    req_len  = 6'd32;
    wr_fmt   = {req_wdata[7:0], req_wdata[15:8], req_wdata[23:16], req_wdata[31:24]};
    if (!req_is_instr) begin
      case (req_size)
        2'd0: begin
          req_len = 6'd8;
          wr_fmt  = {req_wdata[7:0], 24'h0};
        end
        2'd1: begin
          req_len = 6'd16;
          wr_fmt  = {req_wdata[7:0], req_wdata[15:8], 16'h0};
        end
        default: ;
      endcase
    end
    if (!is_write) wr_fmt = 32'h0;
  end

  always_comb begin
    case (data_len_q)
      6'd8:    rd_fmt = {24'h0, m_data_out[7:0]};
      6'd16:   rd_fmt = {16'h0, m_data_out[7:0], m_data_out[15:8]};
      default: rd_fmt = {m_data_out[7:0], m_data_out[15:8], m_data_out[23:16], m_data_out[31:24]};
    endcase
    if (we_q) rd_fmt = 32'h0;
  end

  // An expired session closes before any request is looked at.
  assign timeout_fire = (state_q == IDLE) && sess_open_q && (tmo_cnt_q >= SESS_TIMEOUT);
  assign req_ready    = (state_q == IDLE) && !timeout_fire;
  assign accept       = req_valid && req_ready;

  always_comb begin
    state_d     = state_q;
    sess_open_d = sess_open_q;
    sess_next_d = sess_next_q;
    tmo_cnt_d   = tmo_cnt_q;
    stop_only_d = stop_only_q;
    cont_d      = 1'b0;
    we_d        = we_q;
    instr_d     = instr_q;
    cmd_addr_d  = cmd_addr_q;
    data_len_d  = data_len_q;
    data_in_d   = data_in_q;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE: begin
        if (timeout_fire) begin
          state_d     = STOP;
          stop_only_d = 1'b1;
          sess_open_d = 1'b0;
          tmo_cnt_d   = 8'd0;
        end else if (accept) begin
          tmo_cnt_d  = 8'd0;
          we_d       = is_write;
          instr_d    = req_is_instr;
          cmd_addr_d = {(is_write ? CMD_WRITE : CMD_READ), req_addr};
          data_len_d = req_len;
          data_in_d  = wr_fmt;
          if (sess_open_q && req_is_instr && (req_addr == sess_next_q)) begin
            state_d = WAIT;
            cont_d  = 1'b1;
          end else if (sess_open_q) begin
            state_d     = STOP;
            stop_only_d = 1'b0;
            sess_open_d = 1'b0;
          end else begin
            state_d = START;
          end
        end else if (sess_open_q) begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end
      STOP:  state_d = stop_only_q ? IDLE : START;
      START: state_d = WAIT;
      WAIT: begin
        if (m_done) begin
          state_d = RESP;
          rdata_d = rd_fmt;
          if (instr_q) begin
            sess_open_d = 1'b1;
            sess_next_d = cmd_addr_q[23:0] + 24'd4;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sess_open_q <= 1'b0;
      sess_next_q <= 24'h0;
      tmo_cnt_q   <= 8'd0;
      stop_only_q <= 1'b0;
      cont_q      <= 1'b0;
      we_q        <= 1'b0;
      instr_q     <= 1'b0;
      cmd_addr_q  <= 32'h0;
      data_len_q  <= 6'd0;
      data_in_q   <= 32'h0;
      rdata_q     <= 32'h0;
    end else begin
      state_q     <= state_d;
      sess_open_q <= sess_open_d;
      sess_next_q <= sess_next_d;
      tmo_cnt_q   <= tmo_cnt_d;
      stop_only_q <= stop_only_d;
      cont_q      <= cont_d;
      we_q        <= we_d;
      instr_q     <= instr_d;
      cmd_addr_q  <= cmd_addr_d;
      data_len_q  <= data_len_d;
      data_in_q   <= data_in_d;
      rdata_q     <= rdata_d;
    end
  end

  assign m_start        = (state_q == START);
  assign m_stop         = (state_q == STOP);
  assign m_cont_read    = cont_q;
  assign rsp_valid      = (state_q == RESP);
  assign rsp_rdata      = rdata_q;
  assign m_write_enable = we_q;
  assign m_is_instr     = instr_q;
  assign m_cmd_addr     = cmd_addr_q;
  assign m_data_len     = data_len_q;
  assign m_data_in      = data_in_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Directed bench for spi_mem_ctrl: vector table of bus accesses against a
// small SPI master model, plus session timeout, timeout/request race and reset cases.
module tb_spi_mem_ctrl;

  localparam logic [7:0] SESS_TIMEOUT = 8'd255;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd3;

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_ready, req_is_instr, req_we;
  logic [1:0]  req_size;
  logic [23:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        m_start, m_stop, m_cont_read, m_write_enable, m_is_instr;
  logic [31:0] m_cmd_addr;
  logic [5:0]  m_data_len;
  logic [31:0] m_data_in;
  logic [31:0] m_data_out;
  logic        m_done;
  logic [2:0]  dbg_state;

  spi_mem_ctrl #(
    .CMD_READ(8'h03),
    .CMD_WRITE(8'h02),
    .SESS_TIMEOUT(SESS_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_instr(req_is_instr),
    .req_we(req_we), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .m_start(m_start), .m_stop(m_stop), .m_cont_read(m_cont_read),
    .m_write_enable(m_write_enable), .m_is_instr(m_is_instr),
    .m_cmd_addr(m_cmd_addr), .m_data_len(m_data_len), .m_data_in(m_data_in),
    .m_data_out(m_data_out), .m_done(m_done), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        is_instr;
    logic        we;
    logic [1:0]  size;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic [31:0] dout;
    logic [31:0] exp_cmd;
    logic [5:0]  exp_len;
    logic [31:0] exp_din;
    logic [31:0] exp_rdata;
    int          exp_start;
    int          exp_stop;
    int          exp_cont;
  } vec_t;

  vec_t vecs[13];

  // Results of the last run_access
  logic [31:0] r_rdata, r_cmd, r_din;
  logic [5:0]  r_len;
  int          r_start, r_stop, r_cont, r_adj, r_both;
  bit          r_rsp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Driver + SPI master model: raises the request at the current negedge and
  // answers m_start / m_cont_read with m_done three cycles later.
  task automatic run_access(input vec_t v);
    int cd;
    bit acc_now;
    bit prev_stop;
    r_rdata = 32'h0; r_cmd = 32'h0; r_din = 32'h0; r_len = 6'd0;
    r_start = 0; r_stop = 0; r_cont = 0; r_adj = 0; r_both = 0; r_rsp = 1'b0;
    cd = -1;
    prev_stop = 1'b0;
    req_valid    = 1'b1;
    req_is_instr = v.is_instr;
    req_we       = v.we;
    req_size     = v.size;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
    for (int cyc = 0; cyc < 100 && !r_rsp; cyc++) begin
      acc_now = req_valid && req_ready;
      @(negedge clk);
      if (acc_now) begin
        req_valid = 1'b0;
        req_wdata = 32'hxxxx_xxxx;
      end
      m_done = 1'b0;
      if (m_start) r_start++;
      if (m_stop) r_stop++;
      if (m_cont_read) r_cont++;
      if (m_start && m_stop) r_both++;
      if (prev_stop && m_start) r_adj++;
      prev_stop = m_stop;
      if (m_start || m_cont_read) begin
        r_cmd = m_cmd_addr;
        r_len = m_data_len;
        r_din = m_data_in;
        cd = 3;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          m_done     = 1'b1;
          m_data_out = v.dout;
          cd = -1;
        end
      end
      if (rsp_valid) begin
        r_rsp   = 1'b1;
        r_rdata = rsp_rdata;
      end
    end
    req_valid = 1'b0;
    m_done    = 1'b0;
  endtask

  task automatic check_access(input string tag, input vec_t v);
    logic [31:0] exp;
    exp_q.push_back(v.exp_rdata);
    run_access(v);
    exp = exp_q.pop_front();
    chk({tag, " rsp_seen"}, 32'(r_rsp), 32'd1);
    chk({tag, " rdata"}, r_rdata, exp);
    chk({tag, " cmd_addr"}, r_cmd, v.exp_cmd);
    chk({tag, " data_len"}, 32'(r_len), 32'(v.exp_len));
    chk({tag, " data_in"}, r_din, v.exp_din);
    chk({tag, " n_start"}, 32'(r_start), 32'(v.exp_start));
    chk({tag, " n_stop"}, 32'(r_stop), 32'(v.exp_stop));
    chk({tag, " n_cont"}, 32'(r_cont), 32'(v.exp_cont));
    chk({tag, " stop_then_start"}, 32'(r_adj), 32'(v.exp_stop));
    chk({tag, " stop_start_same_cycle"}, 32'(r_both), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " pulses"}, {26'h0, rsp_valid, m_start, m_stop, m_cont_read, m_write_enable, m_is_instr}, 32'h0);
    chk({tag, " rsp_rdata"}, rsp_rdata, 32'h0);
    chk({tag, " m_cmd_addr"}, m_cmd_addr, 32'h0);
    chk({tag, " m_data_len"}, 32'(m_data_len), 32'h0);
    chk({tag, " m_data_in"}, m_data_in, 32'h0);
  endtask

  initial begin
    vec_t v;
    int   n_stop, n_start, first_stop, n_rsp;
    bit   found;

    rst_n = 1'b0;
    req_valid = 1'b0; req_is_instr = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_addr = 24'h0; req_wdata = 32'h0; m_data_out = 32'h0; m_done = 1'b0;

    //                instr we  size  addr        wdata         dout          cmd           len    din           rdata       st sp ct
    vecs[0]  = '{1'b1, 1'b0, 2'd2, 24'h000100, 32'h0,        32'h13000000, 32'h03000100, 6'd32, 32'h0,        32'h00000013, 1, 0, 0};
    vecs[1]  = '{1'b1, 1'b0, 2'd2, 24'h000104, 32'h0,        32'h00000093, 32'h03000104, 6'd32, 32'h0,        32'h93000000, 0, 0, 1};
    vecs[2]  = '{1'b1, 1'b0, 2'd2, 24'h000200, 32'h0,        32'h11223344, 32'h03000200, 6'd32, 32'h0,        32'h44332211, 1, 1, 0};
    vecs[3]  = '{1'b0, 1'b1, 2'd0, 24'h000010, 32'h000000AB, 32'hFFFFFFFF, 32'h02000010, 6'd8,  32'hAB000000, 32'h00000000, 1, 1, 0};
    vecs[4]  = '{1'b0, 1'b0, 2'd1, 24'h000020, 32'h0,        32'h00003412, 32'h03000020, 6'd16, 32'h0,        32'h00001234, 1, 0, 0};
    vecs[5]  = '{1'b0, 1'b1, 2'd2, 24'h000040, 32'h11223344, 32'h55555555, 32'h02000040, 6'd32, 32'h44332211, 32'h00000000, 1, 0, 0};
    vecs[6]  = '{1'b0, 1'b1, 2'd1, 24'h000042, 32'h0000BEEF, 32'h0,        32'h02000042, 6'd16, 32'hEFBE0000, 32'h00000000, 1, 0, 0};
    vecs[7]  = '{1'b0, 1'b0, 2'd0, 24'h000051, 32'h0,        32'hFFFFFF5A, 32'h03000051, 6'd8,  32'h0,        32'h0000005A, 1, 0, 0};
    vecs[8]  = '{1'b0, 1'b0, 2'd3, 24'h000060, 32'h0,        32'h01020304, 32'h03000060, 6'd32, 32'h0,        32'h04030201, 1, 0, 0};
    vecs[9]  = '{1'b1, 1'b1, 2'd0, 24'h000300, 32'hDEADBEEF, 32'hAABBCCDD, 32'h03000300, 6'd32, 32'h0,        32'hDDCCBBAA, 1, 0, 0};
    vecs[10] = '{1'b0, 1'b0, 2'd2, 24'h000304, 32'h0,        32'h00000000, 32'h03000304, 6'd32, 32'h0,        32'h00000000, 1, 1, 0};
    vecs[11] = '{1'b1, 1'b0, 2'd2, 24'hFFFFFC, 32'h0,        32'h00000001, 32'h03FFFFFC, 6'd32, 32'h0,        32'h01000000, 1, 0, 0};
    vecs[12] = '{1'b1, 1'b0, 2'd2, 24'h000000, 32'h0,        32'h000000FF, 32'h03000000, 6'd32, 32'h0,        32'hFF000000, 0, 0, 1};

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset req_ready", 32'(req_ready), 32'd1);
    chk("post_reset state", 32'(dbg_state), 32'(ST_IDLE));

    for (int i = 0; i < 13; i++) begin
      check_access($sformatf("v%0d", i), vecs[i]);
    end

    // Session left open by the wrapped fetch must close by itself, once.
    n_stop = 0; n_start = 0; first_stop = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (m_stop) begin
        n_stop++;
        if (first_stop < 0) first_stop = i;
      end
      if (m_start) n_start++;
    end
    chk("timeout n_stop", 32'(n_stop), 32'd1);
    chk("timeout n_start", 32'(n_start), 32'd0);
    chk("timeout stop_time_in_window",
        32'((first_stop >= int'(SESS_TIMEOUT)) && (first_stop <= int'(SESS_TIMEOUT) + 3)), 32'd1);
    chk("timeout req_ready", 32'(req_ready), 32'd1);

    // Request landing on the timeout cycle: stop first, then a fresh START.
    v = '{1'b1, 1'b0, 2'd2, 24'h000400, 32'h0, 32'hCAFEF00D, 32'h03000400, 6'd32, 32'h0, 32'h0DF0FECA, 1, 0, 0};
    check_access("race_open", v);
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (dbg_state == ST_IDLE && !req_ready) found = 1'b1;
    end
    chk("race timeout_seen", 32'(found), 32'd1);
    v = '{1'b1, 1'b0, 2'd2, 24'h000404, 32'h0, 32'h12345678, 32'h03000404, 6'd32, 32'h0, 32'h78563412, 1, 1, 0};
    exp_q.push_back(v.exp_rdata);
    run_access(v);
    chk("race rsp_seen", 32'(r_rsp), 32'd1);
    chk("race rdata", r_rdata, exp_q.pop_front());
    chk("race n_stop", 32'(r_stop), 32'd1);
    chk("race n_start", 32'(r_start), 32'd1);
    chk("race n_cont", 32'(r_cont), 32'd0);
    chk("race stop_then_start", 32'(r_adj), 32'd0);

    // Reset while a fetch waits on the SPI master.
    req_valid = 1'b1; req_is_instr = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 24'h000408;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (!req_ready) req_valid = 1'b0;
      if (m_start || m_cont_read) found = 1'b1;
    end
    req_valid = 1'b0;
    chk("rst_mid issued", 32'(found), 32'd1);
    @(negedge clk);
    chk("rst_mid in_wait", 32'(dbg_state), 32'(ST_WAIT));
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    n_rsp = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid) n_rsp++;
    end
    chk("rst_mid no_rsp", 32'(n_rsp), 32'd0);
    v = '{1'b1, 1'b0, 2'd2, 24'h00040C, 32'h0, 32'h00000017, 32'h0300040C, 6'd32, 32'h0, 32'h17000000, 1, 0, 0};
    check_access("post_rst", v);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_mem_ctrl.md
SPI_MEM_CTRL -- requirements
Module: spi_mem_ctrl

Interface
REQ-001 Parameter CMD_READ, 8'h03, SPI read opcode placed in cmd_addr[31:24].
REQ-002 Parameter CMD_WRITE, 8'h02, SPI write opcode.
REQ-003 Parameter SESS_TIMEOUT, 8'd255, idle cycles before an open instruction session is closed.
REQ-004 Reset is rst_n, asynchronous, active-low; clock is clk.
REQ-005 clk  in  1  system clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 req_valid  in  1  bus request present.
REQ-008 req_ready  out  1  request accepted when req_valid & req_ready.
REQ-009 req_is_instr  in  1  1 = instruction fetch (always word), 0 = data access.
REQ-010 req_we  in  1  data write (ignored when req_is_instr).
REQ-011 req_size  in  2  0 byte, 1 half, 2 word (data only).
REQ-012 req_addr  in  24  byte address.
REQ-013 req_wdata  in  32  little-endian write data, right-aligned.
REQ-014 rsp_valid  out  1  one-cycle response strobe.
REQ-015 rsp_rdata  out  32  little-endian read data, right-aligned, zero-extended.
REQ-016 m_start, m_stop, m_cont_read  out  1 each  one-cycle pulses to SPI master.
REQ-017 m_write_enable, m_is_instr  out  1 each  transaction type to SPI master.
REQ-018 m_cmd_addr  out  32  {opcode, addr[23:0]}.
REQ-019 m_data_len  out  6  data-phase bit count (8, 16 or 32).
REQ-020 m_data_in  out  32  MSB-first write data.
REQ-021 m_data_out  in  32  received bits, last bit in [0].
REQ-022 m_done  in  1  one-cycle transaction-complete pulse.

Function
REQ-023 States: IDLE, STOP, START, WAIT, RESP; req_ready high only in IDLE with no pending stop.
REQ-024 Accepted request registers all fields; m_cmd_addr, m_data_len, m_data_in, m_write_enable, m_is_instr held stable from START until m_done.
REQ-025 Continuation: instr fetch with sess_open=1 and req_addr==sess_next_addr -> WAIT with one-cycle m_cont_read, no m_start.
REQ-026 Any other accept with sess_open=1 -> STOP (m_stop one cycle, sess_open cleared) -> START (m_start one cycle) -> WAIT; m_stop and m_start never asserted in the same cycle.
REQ-027 Accept with sess_open=0 -> START -> WAIT.
REQ-028 Opcode CMD_WRITE when req_we & !req_is_instr, else CMD_READ; m_data_len = 32 for instr, 8/16/32 for data by req_size; req_size=3 treated as word.
REQ-029 Write data left-aligned byte-swapped: byte {wdata[7:0],24'h0}; half {wdata[7:0],wdata[15:8],16'h0}; word {wdata[7:0],wdata[15:8],wdata[23:16],wdata[31:24]}.
REQ-030 Read data byte-swapped from m_data_out low bits: byte {24'h0,d[7:0]}; half {16'h0,d[7:0],d[15:8]}; word {d[7:0],d[15:8],d[23:16],d[31:24]}.
REQ-031 WAIT -> RESP on m_done; RESP drives rsp_valid=1 one cycle with rsp_rdata (0 for writes), then IDLE; read latency otherwise unbounded, set by SPI master.
REQ-032 On instr completion: sess_open=1, sess_next_addr = addr+4 modulo 2^24 (wrap 24'hFFFFFC -> 24'h000000); on data completion sess_open stays 0.
REQ-033 Timeout counter counts IDLE cycles with sess_open=1 and no request; reaching SESS_TIMEOUT -> STOP without later START, then IDLE; counter cleared on any accept.
REQ-034 Request arriving in the cycle timeout fires: timeout stop takes priority, request accepted next IDLE cycle as non-continuation.
REQ-035 req_valid deasserted after acceptance has no effect on the in-flight transaction.

Reset
REQ-036 On rst_n low: state IDLE, all pulses, rsp_valid, rsp_rdata, m_* outputs, sess_open, counters 0; req_ready=1 after reset release.
REQ-037 Reset mid-transaction abandons it with no rsp_valid; first post-reset access uses m_start.

Verification
REQ-038 Instr fetch 0x000100, model returns 32'h13000000 -> m_cmd_addr 32'h03000100, len 32, rsp_rdata 32'h00000013.
REQ-039 Fetches 0x000100 then 0x000104 -> second uses m_cont_read only; fetch 0x000200 next -> m_stop, then m_start on the following cycle.
REQ-040 Byte write 0xAB to 0x000010 -> m_cmd_addr 32'h02000010, len 8, m_data_in 32'hAB000000, rsp_rdata 0.
REQ-041 Half read at 0x000020, model d[15:0]=16'h3412 -> rsp_rdata 32'h00001234.
REQ-042 Fetch 0xFFFFFC then 0x000000 -> continuation; then SESS_TIMEOUT idle cycles -> single m_stop, no m_start.
REQ-043 rst_n asserted during WAIT -> all outputs 0 immediately, no rsp_valid; next fetch issues m_start.
